seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider for the 8-bit datapath.
- Inverse of the ALU's add/shift-left path: one shift-left plus trial-subtract per clock.
- Sits beside the ALU in execute and serves divide/modulo operations.
- Uses a start/busy/done handshake so the control unit can stall while a division is in flight.

---
 rtl/seq_divider.sv | 112 +++++++++++
 tb/tb_seq_divider.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one shift plus trial subtract per clock,
// start/busy/done handshake, divide-by-zero flagged and resolved in a single cycle.
module seq_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_ZERO
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_dsr;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH:0]   r_prem;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz;
   logic [WIDTH-1:0] r_quot_out;
   logic [WIDTH-1:0] r_rem_out;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_trial;
   logic             w_fits;
   logic [WIDTH:0]   w_prem_next;
   logic [WIDTH-1:0] w_quo_next;
   logic             w_last;

   // r_quo starts as the dividend; its MSBs feed the remainder while quotient bits
   // shift in at the LSB, so one register serves as both dividend and quotient.
   always_comb begin
      w_shift     = {r_prem[WIDTH-1:0], r_quo[WIDTH-1]};
      w_trial     = {1'b0, w_shift} - {2'b00, r_dsr};
      w_fits      = ~w_trial[WIDTH+1];
      w_prem_next = w_fits ? w_trial[WIDTH:0] : w_shift;
      w_quo_next  = {r_quo[WIDTH-2:0], w_fits};
      w_last      = (r_cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_dsr      <= '0;
         r_quo      <= '0;
         r_prem     <= '0;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_dbz      <= 1'b0;
         r_quot_out <= '0;
         r_rem_out  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_dsr   <= divisor;
                  r_quo   <= dividend;
                  r_prem  <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= (divisor != '0) ? S_RUN : S_ZERO;
               end
            end
            S_RUN: begin
               r_prem <= w_prem_next;
               r_quo  <= w_quo_next;
               r_cnt  <= r_cnt + CW'(1);
               if (w_last) begin
                  r_quot_out <= w_quo_next;
                  r_rem_out  <= w_prem_next[WIDTH-1:0];
                  r_dbz      <= 1'b0;
                  r_done     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            S_ZERO: begin
               r_quot_out <= '1;
               r_rem_out  <= r_quo;
               r_dbz      <= 1'b1;
               r_done     <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quot_out;
   assign remainder   = r_rem_out;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: handshake timing, boundary operands, divide by zero,
// ignored and back-to-back starts, mid-op reset, and a randomised operand sweep.
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_divider #(.WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands, let one edge accept them, then scramble the inputs.
   task automatic launch(input logic [7:0] a, input logic [7:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      chk("busy_on_accept", {31'b0, busy}, 1);
      chk("done_on_accept", {31'b0, done}, 0);
   endtask

   task automatic wait_done(output int cyc);
      logic [7:0] q0, r0;
      logic       ok;
      q0  = quotient;
      r0  = remainder;
      ok  = 1'b1;
      cyc = 0;
      do begin
         tick();
         cyc++;
         if (done !== 1'b1 && (busy !== 1'b1 || quotient !== q0 || remainder !== r0))
            ok = 1'b0;
      end while (done !== 1'b1 && cyc < 20);
      chk("busy_and_hold_until_done", {31'b0, ok}, 1);
      chk("done_within_bound", {31'b0, done}, 1);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                         input logic [7:0] er, input logic ez, input int elat, input bit trail);
      int cyc;
      launch(a, b);
      wait_done(cyc);
      chk("latency", cyc, elat);
      chk("quotient", {24'b0, quotient}, {24'b0, eq});
      chk("remainder", {24'b0, remainder}, {24'b0, er});
      chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, ez});
      chk("busy_at_done", {31'b0, busy}, 0);
      if (trail) begin
         tick();
         chk("done_single_pulse", {31'b0, done}, 0);
         chk("result_held", {16'b0, quotient, remainder}, {16'b0, eq, er});
      end
   endtask

   initial begin
      logic [7:0] a, b;
      int         cyc;
      logic       ok;

      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) tick();
      chk("reset_outputs", {20'b0, busy, done, quotient, remainder, div_by_zero}, 0);
      reset = 1'b0;
      tick();

      run_op(8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 8, 1'b1);
      run_op(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8, 1'b1);
      run_op(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 8, 1'b1);
      run_op(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8, 1'b1);

      run_op(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1, 1'b1);
      run_op(8'd20, 8'd4, 8'd5,  8'd0,  1'b0, 8, 1'b1);

      // Start pulsed mid-op must be ignored; then a start in the done cycle is taken.
      launch(8'd100, 8'd7);
      tick();
      tick();
      dividend = 8'd9;
      divisor  = 8'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      wait_done(cyc);
      chk("ignored_start_latency", cyc, 5);
      chk("ignored_start_result", {16'b0, quotient, remainder}, {16'b0, 8'd14, 8'd2});
      run_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 8, 1'b1);

      launch(8'd200, 8'd9);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("midop_reset_outputs", {20'b0, busy, done, quotient, remainder, div_by_zero}, 0);
      reset = 1'b0;
      ok = 1'b1;
      repeat (12) begin
         tick();
         if (done !== 1'b0) ok = 1'b0;
      end
      chk("no_done_after_abort", {31'b0, ok}, 1);
      run_op(8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 8, 1'b1);

      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom_range(0, 255));
         b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         if (b == 8'd0) begin
            run_op(a, b, 8'hFF, a, 1'b1, 1, 1'b1);
         end else begin
            run_op(a, b, a / b, a % b, 1'b0, 8, 1'b1);
            chk("invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk("rem_lt_divisor", {31'b0, remainder < b}, 1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
